// File: rtl/reg_ctrl_pkg.sv
// Shared defaults and state encoding for the register-file write arbiter.
package reg_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int NREG_DEF   = 8;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: valids plus "B was granted last" pointer in, one-hot grant out.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_b,
  output logic [1:0] o_grant
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_b ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates two register-write requesters onto one registered write port,
// with a zero-fill sweep of the whole register file on request.
module reg_write_arbiter
  import reg_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLR_REQ,
  output logic              CLR_BUSY,
  input  logic              A_VALID,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DATA,
  output logic              A_READY,
  input  logic              B_VALID,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DATA,
  output logic              B_READY,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN,
  output logic              GNT_ID
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREG - 1);

  arb_state_t        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_last_b;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_gnt;
  logic              r_busy;

  logic [1:0]        w_grant;
  logic              w_open;
  logic              w_acc_a;
  logic              w_acc_b;

  rr_arb2 u_rr (
    .i_valid  ({B_VALID, A_VALID}),
    .i_last_b (r_last_b),
    .o_grant  (w_grant)
  );

  // Requesters only see READY when arbitration is actually open this cycle.
  assign w_open  = !RESET && (r_state == ST_ARB) && !CLR_REQ;
  assign A_READY = w_open & w_grant[0];
  assign B_READY = w_open & w_grant[1];
  assign w_acc_a = A_READY & A_VALID;
  assign w_acc_b = B_READY & B_VALID;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= ST_ARB;
      r_cnt    <= '0;
      r_last_b <= SRC_B;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_gnt    <= SRC_A;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (CLR_REQ) begin
            r_state <= ST_CLEAR;
            r_write <= 1'b1;
            r_addr  <= '0;
            r_data  <= '0;
            r_busy  <= 1'b1;
            r_cnt   <= ADDR_W'(1);
          end else if (w_acc_a) begin
            r_write  <= 1'b1;
            r_addr   <= A_ADDR;
            r_data   <= A_DATA;
            r_gnt    <= SRC_A;
            r_last_b <= SRC_A;
          end else if (w_acc_b) begin
            r_write  <= 1'b1;
            r_addr   <= B_ADDR;
            r_data   <= B_DATA;
            r_gnt    <= SRC_B;
            r_last_b <= SRC_B;
          end else begin
            r_write <= 1'b0;
          end
        end
        // r_cnt holds the next sweep address; exit once the last one is on the port.
        ST_CLEAR: begin
          if (r_addr == LAST_ADDR) begin
            r_state <= ST_ARB;
            r_write <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_write <= 1'b1;
            r_addr  <= r_cnt;
            r_data  <= '0;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

  assign WRITE     = r_write;
  assign INADDRESS = r_addr;
  assign IN        = r_data;
  assign GNT_ID    = r_gnt;
  assign CLR_BUSY  = r_busy;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench: arbiter driving a register file, compared against a
// transaction-level model of arbitration, sweeps and final register contents.
module tb_reg_write_arbiter;

  localparam int NREG = 8;

  logic       CLK = 1'b0;
  logic       RESET, CLR_REQ, CLR_BUSY;
  logic       A_VALID, A_READY, B_VALID, B_READY;
  logic [2:0] A_ADDR, B_ADDR, INADDRESS;
  logic [7:0] A_DATA, B_DATA, IN;
  logic       WRITE, GNT_ID;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem    [NREG];
  logic [7:0] refMem [NREG];
  logic       rfClear;

  int         mSweep;
  logic       mLastB, mWrite, mGnt, mBusy;
  logic [2:0] mAddr;
  logic [7:0] mData;

  reg_write_arbiter dut (
    .CLK(CLK), .RESET(RESET), .CLR_REQ(CLR_REQ), .CLR_BUSY(CLR_BUSY),
    .A_VALID(A_VALID), .A_ADDR(A_ADDR), .A_DATA(A_DATA), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_ADDR(B_ADDR), .B_DATA(B_DATA), .B_READY(B_READY),
    .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN), .GNT_ID(GNT_ID)
  );

  always #5 CLK = ~CLK;

  // Register file attached to the write port; it has no reset of its own.
  always @(posedge CLK) begin
    if (rfClear) begin
      for (int i = 0; i < NREG; i++) mem[i] <= 8'h00;
    end else if (WRITE === 1'b1) begin
      mem[INADDRESS] <= IN;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReady(input logic rst, input logic clr, input logic av, input logic bv,
                            output logic ra, output logic rb);
    ra = 1'b0;
    rb = 1'b0;
    if (!rst && mSweep < 0 && !clr) begin
      if (av && bv) begin
        ra = mLastB;
        rb = !mLastB;
      end else begin
        ra = av;
        rb = bv;
      end
    end
  endtask

  task automatic modelStep(input logic rst, input logic clr, input logic accA, input logic accB,
                           input logic [2:0] aa, input logic [7:0] ad,
                           input logic [2:0] ba, input logic [7:0] bd);
    if (rst) begin
      mSweep = -1; mLastB = 1'b1; mWrite = 1'b0;
      mAddr = 3'd0; mData = 8'd0; mGnt = 1'b0; mBusy = 1'b0;
    end else if (mSweep >= 0) begin
      if (mSweep < NREG - 1) begin
        mSweep++;
        mWrite = 1'b1; mAddr = 3'(mSweep); mData = 8'd0;
        refMem[mAddr] = 8'd0;
      end else begin
        mSweep = -1; mWrite = 1'b0; mBusy = 1'b0;
      end
    end else if (clr) begin
      mSweep = 0; mWrite = 1'b1; mAddr = 3'd0; mData = 8'd0; mBusy = 1'b1;
      refMem[0] = 8'd0;
    end else if (accA) begin
      mWrite = 1'b1; mAddr = aa; mData = ad; mGnt = 1'b0; mLastB = 1'b0;
      refMem[aa] = ad;
    end else if (accB) begin
      mWrite = 1'b1; mAddr = ba; mData = bd; mGnt = 1'b1; mLastB = 1'b1;
      refMem[ba] = bd;
    end else begin
      mWrite = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs, check READY, advance the model, check registered outputs.
  task automatic applyStimulus(input logic rst, input logic clr,
                               input logic av, input logic [2:0] aa, input logic [7:0] ad,
                               input logic bv, input logic [2:0] ba, input logic [7:0] bd,
                               output logic accA, output logic accB);
    logic ra, rb;
    RESET = rst; CLR_REQ = clr;
    A_VALID = av; A_ADDR = aa; A_DATA = ad;
    B_VALID = bv; B_ADDR = ba; B_DATA = bd;
    #1;
    modelReady(rst, clr, av, bv, ra, rb);
    checkOutput("A_READY", A_READY, ra);
    checkOutput("B_READY", B_READY, rb);
    accA = av & ra;
    accB = bv & rb;
    modelStep(rst, clr, accA, accB, aa, ad, ba, bd);
    @(posedge CLK);
    #1;
    checkOutput("WRITE", WRITE, mWrite);
    checkOutput("CLR_BUSY", CLR_BUSY, mBusy);
    checkOutput("INADDRESS", INADDRESS, mAddr);
    checkOutput("IN", IN, mData);
    checkOutput("GNT_ID", GNT_ID, mGnt);
  endtask

  task automatic idle(input int n);
    logic xa, xb;
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 3'd0, 8'd0, 0, 3'd0, 8'd0, xa, xb);
  endtask

  task automatic doReset();
    logic xa, xb;
    applyStimulus(1, 0, 0, 3'd0, 8'd0, 0, 3'd0, 8'd0, xa, xb);
  endtask

  task automatic checkMem(input string scen);
    for (int i = 0; i < NREG; i++)
      checkOutput($sformatf("%s_MEM%0d", scen, i), mem[i], refMem[i]);
  endtask

  initial begin
    logic accA, accB, aPend, bPend, rst, clr;
    logic [2:0] aAddr, bAddr;
    logic [7:0] aData, bData;

    for (int i = 0; i < NREG; i++) refMem[i] = 8'h00;
    mSweep = -1; mLastB = 1'b1; mWrite = 1'b0; mAddr = 3'd0;
    mData = 8'd0; mGnt = 1'b0; mBusy = 1'b0;
    rfClear = 1'b1;
    doReset();
    rfClear = 1'b0;
    checkOutput("RST_WRITE", WRITE, 0);
    checkOutput("RST_BUSY", CLR_BUSY, 0);

    $display("[TB] single write from A");
    applyStimulus(0, 0, 1, 3'd2, 8'd95, 0, 3'd0, 8'd0, accA, accB);
    checkOutput("S1_IN", IN, 95);
    checkOutput("S1_GNT", GNT_ID, 0);
    idle(2);
    checkMem("S1");

    $display("[TB] sustained contention");
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, 3'd1, 8'd28, 1, 3'd4, 8'd6, accA, accB);
      checkOutput($sformatf("S2_GNT%0d", i), GNT_ID, i % 2);
    end
    idle(2);
    checkMem("S2");

    $display("[TB] sweep with pending A request");
    applyStimulus(0, 1, 1, 3'd5, 8'd77, 0, 3'd0, 8'd0, accA, accB);
    checkOutput("S3_NOACC", accA, 0);
    aPend = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clr = (i == 3);
      applyStimulus(0, clr, aPend, 3'd5, 8'd77, 0, 3'd0, 8'd0, accA, accB);
      if (accA) aPend = 1'b0;
    end
    checkOutput("S3_SERVED", aPend, 0);
    idle(2);
    checkMem("S3");

    $display("[TB] reset mid-sweep");
    for (int i = 0; i < NREG; i++) refMem[i] = 8'hA0 + 8'(i);
    rfClear = 1'b0;
    for (int i = 0; i < NREG; i++) applyStimulus(0, 0, 1, 3'(i), 8'hA0 + 8'(i), 0, 3'd0, 8'd0, accA, accB);
    applyStimulus(0, 1, 0, 3'd0, 8'd0, 0, 3'd0, 8'd0, accA, accB);
    idle(3);
    checkOutput("S4_ADDR3", INADDRESS, 3);
    doReset();
    checkOutput("S4_WRITE", WRITE, 0);
    checkOutput("S4_BUSY", CLR_BUSY, 0);
    idle(3);
    checkMem("S4");

    $display("[TB] same-address collision");
    doReset();
    aPend = 1'b1; bPend = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, aPend, 3'd7, 8'd15, bPend, 3'd7, 8'd50, accA, accB);
      if (accA) aPend = 1'b0;
      if (accB) bPend = 1'b0;
    end
    idle(2);
    checkMem("S5");
    checkOutput("S5_LAST", mem[7], 50);

    $display("[TB] randomized traffic");
    aPend = 1'b0; bPend = 1'b0;
    aAddr = 3'd0; bAddr = 3'd0; aData = 8'd0; bData = 8'd0;
    for (int i = 0; i < 400; i++) begin
      if (!aPend && $urandom_range(9) < 6) begin
        aPend = 1'b1; aAddr = 3'($urandom); aData = 8'($urandom);
      end
      if (!bPend && $urandom_range(9) < 6) begin
        bPend = 1'b1; bAddr = 3'($urandom); bData = 8'($urandom);
      end
      rst = ($urandom_range(99) == 0);
      clr = ($urandom_range(39) == 0);
      applyStimulus(rst, clr, aPend, aAddr, aData, bPend, bAddr, bData, accA, accB);
      if (accA) aPend = 1'b0;
      if (accB) bPend = 1'b0;
    end
    idle(NREG + 2);
    checkMem("RND");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
